// File: rtl/instr_fetch_unit_pkg.sv
// Shared widths, defaults and the instruction-queue entry layout for the fetch stage.
package instr_fetch_unit_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_W     = 32;
    localparam int FETCH_DEPTH = 2;

    localparam logic [XLEN-1:0] RESET_PC_DEF = '0;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Small synchronous FIFO with flush; head is read straight from storage (no bypass).
// Push while full is accepted only together with a pop.
module instr_fetch_unit_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: credit-limited in-order imem requests, PC-tagged instruction queue to decode;
// redirect flushes and drops in-flight responses. FETCH_PERF_CNT_EN adds perf counters.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int              DEPTH    = FETCH_DEPTH,
    parameter int              CNT_W    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt,
`endif
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [XLEN-1:0]    dec_pc
);

    logic [XLEN-1:0]  pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] drop;
    logic [CNT_W:0]   credits_used;
    logic             req_fire;
    logic             dec_fire;
    logic             q_push;
    logic [XLEN-1:0]  tag_pc;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    assign credits_used   = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = !reset && !redirect_valid && (credits_used < (CNT_W+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               pc <= RESET_PC;
        else if (redirect_valid) pc <= {redirect_pc[XLEN-1:2], 2'b00};
        else if (req_fire)       pc <= pc + XLEN'(4);
    end

    // Recomputing drop from outstanding lets back-to-back redirects accumulate correctly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                drop <= '0;
        else if (redirect_valid)                  drop <= outstanding_next;
        else if (imem_rsp_valid && drop != '0)    drop <= drop - 1'b1;
    end

    // Tag FIFO is never flushed: stale responses still consume their tag, and its
    // occupancy is exactly the outstanding-request count.
    instr_fetch_unit_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (pc),
        .pop       (imem_rsp_valid),
        .head      (tag_pc),
        .count     (outstanding)
    );

    assign q_push     = imem_rsp_valid && (drop == '0);
    assign push_entry = '{pc: tag_pc, instr: imem_rsp_data};

    instr_fetch_unit_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_instr_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (q_push),
        .push_data (push_entry),
        .pop       (dec_fire),
        .head      (head),
        .count     (count)
    );

    assign dec_valid = (count != '0);
    assign dec_fire  = dec_valid && dec_ready;
    assign dec_instr = dec_valid ? head.instr : '0;
    assign dec_pc    = dec_valid ? head.pc    : '0;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (dec_fire) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (dec_ready && !dec_valid && !redirect_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model, decode scoreboard, redirect vector table.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_req  = 0;
    int n_dec  = 0;
    int lat_lo = 1;
    int lat_hi = 1;
    int rdy_mode  = 0;
    int drdy_mode = 1;
    int exp_fetch = 0;
    int exp_stall = 0;
    logic [31:0] model_pc;
    logic [31:0] last_req_addr;
    logic [31:0] last_dec_pc;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_first;
        logic [31:0] exp_second;
        int          lat;
    } redir_vec_t;

    mreq_t      mq[$];
    exp_t       sb[$];
    redir_vec_t vecs [4];

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[17:2]} ^ 32'h5a3c_0f96;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_perf();
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch_cnt", perf_fetch_cnt, 32'(exp_fetch));
        check("perf_stall_cnt", perf_stall_cnt, 32'(exp_stall));
`endif
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic cycle(input logic rd, input logic [31:0] rd_addr);
        exp_t e;
        redirect_valid = rd;
        redirect_pc    = rd_addr;
        case (drdy_mode)
            0:       dec_ready = 1'b0;
            1:       dec_ready = 1'b1;
            default: dec_ready = 1'($urandom_range(0, 1));
        endcase
        case (rdy_mode)
            0:       imem_req_ready = 1'b1;
            1:       imem_req_ready = ((cyc % 2) == 0);
            default: imem_req_ready = 1'($urandom_range(0, 1));
        endcase
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hdead_beef;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, model_pc);
            mq.push_back('{addr: imem_req_addr, due: cyc + int'($urandom_range(lat_lo, lat_hi))});
            sb.push_back('{pc: model_pc, instr: mem_word(model_pc)});
            model_pc      = model_pc + 32'd4;
            last_req_addr = imem_req_addr;
            n_req++;
        end
        if (imem_rsp_valid) mq.delete(0);
        if (dec_valid && dec_ready) begin
            n_dec++;
            exp_fetch++;
            last_dec_pc = dec_pc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dec_extra: got pc %h, expected no instruction", dec_pc);
            end else begin
                e = sb.pop_front();
                check("dec_pc", dec_pc, e.pc);
                check("dec_instr", dec_instr, e.instr);
            end
        end
        if (dec_ready && !dec_valid && !rd) exp_stall++;
        if (rd) begin
            check("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
            sb.delete();
            model_pc = {rd_addr[31:2], 2'b00};
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0);
    endtask

    task automatic wait_req(input int target, input string name, input logic [31:0] exp);
        int k = 0;
        while (n_req < target && k < 40) begin
            cycle(1'b0, 32'h0);
            k++;
        end
        if (n_req < target) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, no request issued, expected addr %h", name, exp);
        end else begin
            check(name, last_req_addr, exp);
        end
    endtask

    task automatic wait_dec(input int target, input string name, input logic [31:0] exp);
        int k = 0;
        while (n_dec < target && k < 40) begin
            cycle(1'b0, 32'h0);
            k++;
        end
        if (n_dec < target) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, no decode handshake, expected pc %h", name, exp);
        end else begin
            check(name, last_dec_pc, exp);
        end
    endtask

    // Asserts reset at the current point (asynchronously), checks outputs, releases at next falling edge.
    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, RST_PC);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_dec_instr", dec_instr, 32'd0);
        check("rst_dec_pc", dec_pc, 32'd0);
        mq.delete();
        sb.delete();
        model_pc  = RST_PC;
        exp_fetch = 0;
        exp_stall = 0;
        check_perf();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{target: 32'h0000_0103, exp_first: 32'h0000_0100, exp_second: 32'h0000_0104, lat: 3};
        vecs[1] = '{target: 32'hFFFF_FFFF, exp_first: 32'hFFFF_FFFC, exp_second: 32'h0000_0000, lat: 1};
        vecs[2] = '{target: 32'h0000_0206, exp_first: 32'h0000_0204, exp_second: 32'h0000_0208, lat: 2};
        vecs[3] = '{target: 32'h0000_1001, exp_first: 32'h0000_1000, exp_second: 32'h0000_1004, lat: 3};

        reset = 1'b1;
        @(negedge clk);
        do_reset();

        // Sequential fetch with a 1-cycle memory; first instruction visible two cycles after reset.
        lat_lo = 1; lat_hi = 1; rdy_mode = 0; drdy_mode = 1;
        cycle(1'b0, 32'h0);
        check("t1_no_bypass", 32'(dec_valid), 32'd0);
        cycle(1'b0, 32'h0);
        check("t1_first_valid", 32'(dec_valid), 32'd1);
        check("t1_first_pc", dec_pc, RST_PC);
        check("t1_first_instr", dec_instr, mem_word(RST_PC));
        n_dec = 0;
        run(30);
        check("t1_progress", 32'(n_dec >= 18), 32'd1);
        check_perf();

        // Decode stalled: credits cap requests at the queue depth.
        do_reset();
        drdy_mode = 0;
        n_req = 0;
        run(10);
        check("t2_req_count", 32'(n_req), 32'd2);
        check("t2_req_blocked", 32'(imem_req_valid), 32'd0);
        check("t2_queue_valid", 32'(dec_valid), 32'd1);
        drdy_mode = 1;
        n_dec = 0;
        run(10);
        check("t2_drain", 32'(n_dec >= 4), 32'd1);
        check_perf();

        // Redirect vectors with responses still in flight.
        for (int i = 0; i < 4; i++) begin
            lat_lo = vecs[i].lat; lat_hi = vecs[i].lat; rdy_mode = 0; drdy_mode = 1;
            run(3);
            cycle(1'b1, vecs[i].target);
            n_req = 0;
            n_dec = 0;
            wait_req(1, "vec_first_req", vecs[i].exp_first);
            wait_dec(1, "vec_first_dec", vecs[i].exp_first);
            wait_dec(2, "vec_second_dec", vecs[i].exp_second);
        end
        check_perf();

        // Toggling request ready, random response latency and decode ready.
        lat_lo = 1; lat_hi = 3; rdy_mode = 1; drdy_mode = 2;
        n_dec = 0;
        run(300);
        check("t4_toggle_progress", 32'(n_dec >= 30), 32'd1);
        rdy_mode = 2;
        n_dec = 0;
        run(200);
        check("t4_random_progress", 32'(n_dec >= 20), 32'd1);
        check_perf();

        // Back-to-back redirects: the second target wins.
        lat_lo = 3; lat_hi = 3; rdy_mode = 0; drdy_mode = 1;
        run(3);
        cycle(1'b1, 32'h0000_0200);
        cycle(1'b1, 32'h0000_0300);
        n_req = 0;
        n_dec = 0;
        wait_req(1, "t5_first_req", 32'h0000_0300);
        wait_dec(1, "t5_first_dec", 32'h0000_0300);
        run(10);
        check_perf();

        // Reset mid-stream with a full queue, then restart.
        lat_lo = 1; lat_hi = 1; drdy_mode = 0;
        run(6);
        check("t6_full_valid", 32'(dec_valid), 32'd1);
        check("t6_full_blocked", 32'(imem_req_valid), 32'd0);
        check_perf();
        do_reset();
        drdy_mode = 1;
        n_dec = 0;
        wait_dec(1, "t6_restart_pc", RST_PC);
        run(5);
        check_perf();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
